// File: rtl/flag_fifo_pkg.sv
// flag_fifo shared constants and elaboration helpers.
// Keeps parameter legality rules in one place for the buffer.
package flag_fifo_pkg;

    localparam int FF_MIN_DEPTH = 2;

    function automatic bit ff_is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit ff_params_ok(input int depth, input int af);
        return ff_is_pow2(depth) && (depth >= FF_MIN_DEPTH)
            && (af >= 1) && (af <= depth);
    endfunction

endpackage

// File: rtl/flag_fifo.sv
// Multi-entry flag buffer with occupancy, sticky overrun and
// selectable full-buffer policy (drop newest / overwrite oldest).
module flag_fifo
    import flag_fifo_pkg::*;
#(
    parameter int W         = 8,
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = 0,
    parameter int AF_LEVEL  = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     set_flag,
    input  logic                     clr_flag,
    input  logic [W-1:0]             din,
    input  logic                     clr_overrun,
    output logic                     flag,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
    localparam bit            C_OVW   = (OVERWRITE != 0);

    generate
        if (!ff_params_ok(DEPTH, AF_LEVEL)) begin : g_bad_params
            $error("flag_fifo: DEPTH must be pow2 >= 2, AF_LEVEL in 1..DEPTH");
        end
    endgenerate

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overrun;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;
    logic w_adv_rd;
    logic w_ovr_set;
    logic w_inc;
    logic w_dec;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_DEPTH);
    assign w_pop   = clr_flag && !w_empty;

    // Full with a simultaneous pop is an ordinary exchange, not an overrun.
    assign w_ovr_set = set_flag && w_full && !clr_flag;
    assign w_wr      = set_flag && (!w_full || clr_flag || C_OVW);
    assign w_adv_rd  = w_pop || (w_ovr_set && C_OVW);
    assign w_inc     = w_wr && !w_adv_rd;
    assign w_dec     = w_adv_rd && !w_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_adv_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_inc) begin
                r_count <= r_count + 1'b1;
            end else if (w_dec) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Set has priority over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign flag        = !w_empty;
    assign dout        = w_empty ? '0 : r_mem[r_rd_ptr];
    assign full        = w_full;
    assign almost_full = (r_count >= C_AF);
    assign count       = r_count;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_flag_fifo.sv
// Bench for flag_fifo: drop and overwrite policies side by side,
// checked every cycle against a queue-based reference.
module tb_flag_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       set_flag = 1'b0;
    logic       clr_flag = 1'b0;
    logic [7:0] din = '0;
    logic       clr_overrun = 1'b0;

    logic       flag0, full0, af0, ovr0;
    logic [7:0] dout0;
    logic [2:0] cnt0;
    logic       flag1, full1, af1, ovr1;
    logic [7:0] dout1;
    logic [2:0] cnt1;

    int vec = 0;
    int bad = 0;

    always #5 clk = ~clk;

    flag_fifo #(.W(8), .DEPTH(4), .OVERWRITE(0)) dut0 (
        .clk(clk), .reset(reset), .set_flag(set_flag),
        .clr_flag(clr_flag), .din(din), .clr_overrun(clr_overrun),
        .flag(flag0), .dout(dout0), .full(full0),
        .almost_full(af0), .count(cnt0), .overrun(ovr0)
    );

    flag_fifo #(.W(8), .DEPTH(4), .OVERWRITE(1)) dut1 (
        .clk(clk), .reset(reset), .set_flag(set_flag),
        .clr_flag(clr_flag), .din(din), .clr_overrun(clr_overrun),
        .flag(flag1), .dout(dout1), .full(full1),
        .almost_full(af1), .count(cnt1), .overrun(ovr1)
    );

    // Reference: index 0 = drop policy, index 1 = overwrite policy.
    logic [7:0] mq [2][$];
    bit         mov [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                mq[p].delete();
                mov[p] = 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                int  n;
                bit  ovs;
                n   = mq[p].size();
                ovs = set_flag && !clr_flag && (n == 4);
                if (clr_flag && n > 0) void'(mq[p].pop_front());
                if (set_flag) begin
                    if (mq[p].size() < 4) begin
                        mq[p].push_back(din);
                    end else if (p == 1) begin
                        void'(mq[p].pop_front());
                        mq[p].push_back(din);
                    end
                end
                if (ovs) mov[p] = 1'b1;
                else if (clr_overrun) mov[p] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vec++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            int n0, n1;
            n0 = mq[0].size();
            n1 = mq[1].size();
            chk("flag0", int'(flag0), int'(n0 != 0));
            chk("count0", int'(cnt0), n0);
            chk("full0", int'(full0), int'(n0 == 4));
            chk("af0", int'(af0), int'(n0 >= 3));
            chk("dout0", int'(dout0), n0 != 0 ? int'(mq[0][0]) : 0);
            chk("ovr0", int'(ovr0), int'(mov[0]));
            chk("flag1", int'(flag1), int'(n1 != 0));
            chk("count1", int'(cnt1), n1);
            chk("full1", int'(full1), int'(n1 == 4));
            chk("af1", int'(af1), int'(n1 >= 3));
            chk("dout1", int'(dout1), n1 != 0 ? int'(mq[1][0]) : 0);
            chk("ovr1", int'(ovr1), int'(mov[1]));
        end
    end

    task automatic cyc(input bit s, input bit c, input logic [7:0] d,
                       input bit co);
        @(negedge clk);
        set_flag    = s;
        clr_flag    = c;
        din         = d;
        clr_overrun = co;
    endtask

    task automatic idle();
        cyc(0, 0, 8'h00, 0);
    endtask

    // Check head literals of both policies, then pop one word.
    task automatic pop_chk(input logic [7:0] e0, input logic [7:0] e1);
        @(negedge clk);
        chk("lit_head0", int'(dout0), int'(e0));
        chk("lit_head1", int'(dout1), int'(e1));
        set_flag    = 0;
        clr_flag    = 1;
        din         = 8'h00;
        clr_overrun = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_count", int'(cnt0), 0);
        chk("rst_dout", int'(dout0), 0);
        chk("rst_flag", int'(flag1), 0);
        reset = 1'b0;

        // Single push / pop.
        cyc(1, 0, 8'hA5, 0);
        idle();
        chk("lit_a5_dout", int'(dout0), 'hA5);
        chk("lit_a5_cnt", int'(cnt1), 1);
        cyc(0, 1, 8'h00, 0);
        idle();
        chk("lit_pop_flag", int'(flag0), 0);
        chk("lit_pop_dout", int'(dout1), 0);

        // Fill, then push while full.
        for (int i = 1; i <= 4; i++) cyc(1, 0, 8'(i), 0);
        idle();
        chk("lit_full", int'(full0), 1);
        cyc(1, 0, 8'h55, 0);
        idle();
        chk("lit_ovr0", int'(ovr0), 1);
        chk("lit_ovr1", int'(ovr1), 1);
        chk("lit_cnt_full", int'(cnt0), 4);
        pop_chk(8'h01, 8'h02);
        pop_chk(8'h02, 8'h03);
        pop_chk(8'h03, 8'h04);
        pop_chk(8'h04, 8'h55);
        cyc(0, 0, 8'h00, 1);
        idle();
        chk("lit_ovr_clr", int'(ovr0), 0);

        // Simultaneous push+pop: empty, mid, full.
        cyc(1, 1, 8'h11, 0);
        cyc(1, 0, 8'h22, 0);
        cyc(1, 1, 8'h33, 0);
        cyc(1, 0, 8'h44, 0);
        cyc(1, 0, 8'h55, 0);
        cyc(1, 1, 8'h66, 0);
        idle();
        chk("lit_xchg_ovr", int'(ovr0), 0);
        pop_chk(8'h33, 8'h33);
        pop_chk(8'h44, 8'h44);
        pop_chk(8'h55, 8'h55);
        pop_chk(8'h66, 8'h66);
        cyc(0, 1, 8'h00, 0);
        idle();
        chk("lit_empty_pop", int'(cnt0), 0);

        // Overrun set beats a coincident clear.
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'h70 + 8'(i), 0);
        cyc(1, 0, 8'h77, 1);
        idle();
        chk("lit_set_wins", int'(ovr0), 1);
        cyc(0, 0, 8'h00, 1);
        repeat (4) cyc(0, 1, 8'h00, 0);

        // Push 6 / pop 6 across several pointer laps.
        for (int lap = 0; lap < 4; lap++) begin
            for (int i = 0; i < 6; i++) cyc(1, 0, 8'(lap * 16 + i), 0);
            for (int i = 0; i < 6; i++) cyc(0, 1, 8'h00, 0);
            cyc(0, 0, 8'h00, 1);
        end

        // Asynchronous reset mid-burst.
        cyc(1, 0, 8'hC1, 0);
        cyc(1, 0, 8'hC2, 0);
        cyc(1, 0, 8'hC3, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("lit_arst_cnt", int'(cnt0), 0);
        chk("lit_arst_flag", int'(flag1), 0);
        chk("lit_arst_dout", int'(dout0), 0);
        chk("lit_arst_ovr", int'(ovr1), 0);
        set_flag = 0;
        clr_flag = 0;
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 0, 8'h5A, 0);
        idle();
        chk("lit_post_dout", int'(dout1), 'h5A);
        chk("lit_post_cnt", int'(cnt0), 1);
        repeat (2) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/flag_fifo.md
# flag_fifo

Multi-entry, parametrised successor to the UART single-entry flag buffer. It sits between the UART receiver (or transmit interface) and the consumer, and absorbs bursts of up to DEPTH words. It keeps the set_flag/clr_flag handshake and adds occupancy reporting, a sticky overrun flag, and a selectable full-buffer policy (drop newest or overwrite oldest).

## Interface
- W, 8, data word width in bits
- DEPTH, 4, number of entries; power of two, ≥2
- OVERWRITE, 0, full-buffer policy: 0 = drop incoming word; 1 = overwrite oldest entry
- AF_LEVEL, DEPTH-1, almost_full threshold; 1..DEPTH
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- set_flag  in  1  push din
- clr_flag  in  1  pop head entry
- din  in  W  write data
- clr_overrun  in  1  clear sticky overrun
- flag  out  1  buffer non-empty (count≠0)
- dout  out  W  head entry; 0 when empty
- full  out  1  count==DEPTH
- almost_full  out  1  count≥AF_LEVEL
- count  out  $clog2(DEPTH)+1  occupancy
- overrun  out  1  sticky: push attempted while full without a simultaneous pop

## Operation
- Storage: DEPTH×W array; rd_ptr/wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. count is a separate register.
- Reset: pointers, count, array and overrun all 0; flag=0, full=0, almost_full=0 (since AF_LEVEL≥1), dout=0.
- Push only, not full: write mem[wr_ptr]=din, wr_ptr+1, count+1.
- Pop only, not empty: rd_ptr+1, count−1. Pop on empty is ignored, with no error and no state change.
- Push+pop, 0<count<DEPTH: write and read both occur; count unchanged.
- Push+pop on empty: push only, count becomes 1.
- Push+pop on full: pop head, write din; count stays DEPTH; no overrun.
- Push only on full, OVERWRITE=0: din discarded; all state unchanged except overrun←1.
- Push only on full, OVERWRITE=1: mem[wr_ptr]=din, wr_ptr+1, rd_ptr+1 (oldest lost), count stays DEPTH, overrun←1.
- overrun stays set until clr_overrun. If a set condition and clr_overrun occur in the same cycle, set wins.
- dout = flag ? mem[rd_ptr] : 0 (combinational from registered state).

## Timing
- Single clock domain; all state updates on posedge clk.
- Push at edge k: flag, count, full, almost_full and dout (if buffer was empty) are valid after edge k. Latency is 1 cycle.
- Pop at edge k: the next entry appears on dout after edge k. Consumers sample dout while flag=1, then assert clr_flag for one cycle per word.
- A clr_flag held high pops one entry per cycle.
- No combinational path from inputs to outputs.
- reset asserted mid-operation clears all content immediately (asynchronously). Pushes coincident with reset are lost.

## Structure
- No shared-package typedefs are required. Pointer and count widths are localparams derived from DEPTH.
- Add an elaboration-time check for power-of-two DEPTH ≥2 and 1≤AF_LEVEL≤DEPTH.
- The storage array and pointer logic stay inline; no sub-module.
- DEPTH=1 behaviour is covered by the existing single-entry buffer and is not supported here.

## Test plan
- Reset, then push 0xA5 → flag=1, count=1, dout=0xA5 the next cycle. Pop → flag=0, dout=0.
- DEPTH=4: push 0x01..0x04 → full=1, almost_full=1 from count 3. Pop ×4 → dout 0x01,0x02,0x03,0x04 in order, then empty.
- OVERWRITE=0, full with 0x01..0x04, push 0x55 → overrun=1, count=4, pops return 0x01..0x04. Pulse clr_overrun → overrun=0.
- OVERWRITE=1, full with 0x01..0x04, push 0x55 → overrun=1, pops return 0x02,0x03,0x04,0x55.
- Simultaneous push+pop on empty (count→1), mid (count unchanged), and full (no overrun, FIFO order kept). Pop on empty → no change. clr_overrun during an overrun-setting push → overrun stays 1.
- Push 6 then pop 6 repeatedly across pointer wrap (≥3 laps). Assert reset mid-burst → all outputs 0 at once, next push behaves as after power-up.
